// File: rtl/cnt_uart_pkg.sv
// Shared types and constants for the ring-oscillator counter UART transmitter.
package cnt_uart_pkg;

    // Transmitter FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_STOP    = 3'd4
    } state_t;

    // Line level while idle / during the stop bit.
    localparam logic IDLE_LEVEL   = 1'b1;
    // Line level during the start bit.
    localparam logic START_LEVEL  = 1'b0;
    // Payload bits per frame.
    localparam int   DATA_BITS    = 8;
    // Stability count that marks three identical synchronised samples.
    localparam int   STABLE_COUNT = 2;

endpackage

// File: rtl/cnt_sync_stable.sv
// Brings the asynchronous counter bus into the clk domain and flags when the
// synchronised value has held still long enough to be trusted as one sample.
module cnt_sync_stable
    import cnt_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cnt_i,
    output logic [7:0] sync_o,
    output logic       stable_o
);

    logic [7:0] s1_q;
    logic [7:0] s2_q;
    logic [7:0] s3_q;
    logic [1:0] stab_q;
    logic [1:0] stab_d;

    // Stability counter: counts consecutive equal s2/s3 pairs, saturating at the threshold.
    always_comb begin
        stab_d = stab_q;
        if (s2_q == s3_q) begin
            if (stab_q == 2'(STABLE_COUNT)) begin
                stab_d = stab_q;
            end else begin
                stab_d = stab_q + 2'd1;
            end
        end else begin
            stab_d = 2'd0;
        end
    end

    // Two-flop synchroniser, one-cycle delay stage and stability counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            s3_q   <= 8'h00;
            stab_q <= 2'd0;
        end else begin
            s1_q   <= cnt_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            stab_q <= stab_d;
        end
    end

    assign sync_o   = s2_q;
    assign stable_o = (stab_q == 2'(STABLE_COUNT));

endmodule

// File: rtl/cnt_uart_tx.sv
// Samples the ring-oscillator counter and sends each sample as one 8N1 UART
// frame. All outputs are registered; tx is computed from the next state so it
// lines up with the state register without any input-to-tx combinational path.
module cnt_uart_tx
    import cnt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CAPT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] cnt_in,
    input  logic       start,
    input  logic       auto_mode,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] sample_out,
    output logic       unstable
);

    localparam int              BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
    localparam logic [3:0]      TMO_LAST  = 4'(CAPT_TIMEOUT - 1);
    // Earliest timeout-counter value at which a stable sample may be taken,
    // giving a CAPTURE phase of at least three cycles.
    localparam logic [3:0]      TMO_MIN   = 4'd2;
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    logic [7:0]    sync_s;
    logic          stable_s;

    state_t        state_q,  state_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [2:0]    bit_q,    bit_d;
    logic [3:0]    tmo_q,    tmo_d;
    logic [7:0]    sample_q, sample_d;
    logic          unst_q,   unst_d;
    logic          tx_q,     tx_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic          bit_end_s;

    cnt_sync_stable u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_i    (cnt_in),
        .sync_o   (sync_s),
        .stable_o (stable_s)
    );

    assign bit_end_s = (baud_q == BAUD_LAST);

    // Next-state logic for the FSM, baud counter, bit index and capture timeout.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        tmo_d    = tmo_q;
        sample_d = sample_q;
        unst_d   = unst_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (ena && (start || auto_mode)) begin
                    state_d = ST_CAPTURE;
                    tmo_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (stable_s && (tmo_q >= TMO_MIN)) begin
                    state_d  = ST_START;
                    sample_d = sync_s;
                    unst_d   = 1'b0;
                    baud_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_START;
                    sample_d = sync_s;
                    unst_d   = 1'b1;
                    baud_d   = '0;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (ena && auto_mode) begin
                        state_d = ST_CAPTURE;
                        tmo_d   = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Output next values derived from the next state so the registers align with state_q.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
        case (state_d)
            ST_START: tx_d = START_LEVEL;
            ST_DATA:  tx_d = sample_d[bit_d];
            default:  tx_d = IDLE_LEVEL;
        endcase
    end

    // State and output registers; reset drives the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            tmo_q    <= 4'd0;
            sample_q <= 8'h00;
            unst_q   <= 1'b0;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tmo_q    <= tmo_d;
            sample_q <= sample_d;
            unst_q   <= unst_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_out = sample_q;
    assign unstable   = unst_q;

endmodule

// File: tb/tb_cnt_uart_tx.sv
// Directed bench for cnt_uart_tx with CLKS_PER_BIT=4 and CAPT_TIMEOUT=15.
module tb_cnt_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] cnt_in;
    logic       start;
    logic       auto_mode;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] sample_out;
    logic       unstable;

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_bg = 1'b0;

    localparam logic [39:0] DONE_EXP = 40'h80_0000_0000;

    cnt_uart_tx #(.CLKS_PER_BIT(4), .CAPT_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cnt_in     (cnt_in),
        .start      (start),
        .auto_mode  (auto_mode),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .sample_out (sample_out),
        .unstable   (unstable)
    );

    always #5 clk = ~clk;

    // Expected tx level on each of the 40 cycles of a frame carrying b.
    function automatic logic [39:0] exp_frame(input logic [7:0] b);
        logic [39:0] f;
        int k;
        for (int i = 0; i < 40; i++) begin
            k = i / 4;
            if (k == 0)      f[i] = 1'b0;
            else if (k == 9) f[i] = 1'b1;
            else             f[i] = b[k-1];
        end
        return f;
    endfunction

    // Byte recovered from mid-bit samples of a recorded frame.
    function automatic logic [7:0] decode(input logic [39:0] f);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = f[4*(k+1)+2];
        return d;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a frame, counts CAPTURE cycles and records tx/done per cycle.
    task automatic capture_frame(input int start_at, input int ena_drop_at,
                                 output int cap, output logic [39:0] txv,
                                 output logic [39:0] donev, output bit to);
        int n;
        to = 1'b0; cap = 0; n = 0;
        while (busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        while (busy === 1'b1 && tx === 1'b1 && n < 100) begin cap++; @(negedge clk); n++; end
        if (tx !== 1'b0) to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == start_at) start = 1'b1;
            else if (i == start_at + 1) start = 1'b0;
            if (i == ena_drop_at) ena = 1'b0;
            txv[i]   = tx;
            donev[i] = done;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b1; auto_mode = 1'b0; cnt_in = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (sample_out !== 8'h00) begin n_fail++; $display("FAIL reset_sample: got %h want 00", sample_out); end
        n_cmp++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL reset_unstable: got %b want 0", unstable); end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int cap; logic [39:0] txv, donev; bit to;
        cnt_in = 8'hA5;
        repeat (6) @(negedge clk);
        pulse_start();
        capture_frame(-1, -1, cap, txv, donev, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout want frame"); end
        n_cmp++; if (cap < 3 || cap > 5) begin n_fail++; $display("FAIL basic_capture_len: got %0d want 3..5", cap); end
        n_cmp++; if (txv !== exp_frame(8'hA5)) begin n_fail++; $display("FAIL basic_tx: got %h want %h", txv, exp_frame(8'hA5)); end
        n_cmp++; if (donev !== DONE_EXP) begin n_fail++; $display("FAIL basic_done: got %h want %h", donev, DONE_EXP); end
        n_cmp++; if (sample_out !== 8'hA5) begin n_fail++; $display("FAIL basic_sample: got %h want a5", sample_out); end
        n_cmp++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL basic_unstable: got %b want 0", unstable); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL basic_tx_after: got %b want 1", tx); end
    endtask

    task automatic test_unstable();
        int cap; logic [39:0] txv, donev; bit to;
        cnt_in = 8'h00;
        run_bg = 1'b1;
        fork
            begin
                while (run_bg) begin @(negedge clk); cnt_in = ~cnt_in; end
            end
            begin
                repeat (6) @(negedge clk);
                pulse_start();
                capture_frame(-1, -1, cap, txv, donev, to);
                run_bg = 1'b0;
            end
        join
        n_cmp++; if (cap != 15 || to) begin n_fail++; $display("FAIL unstable_capture_len: got %0d want 15", cap); end
        n_cmp++; if (unstable !== 1'b1) begin n_fail++; $display("FAIL unstable_flag: got %b want 1", unstable); end
        n_cmp++; if (sample_out !== 8'h00 && sample_out !== 8'hFF) begin n_fail++; $display("FAIL unstable_sample: got %h want 00 or ff", sample_out); end
        n_cmp++; if (decode(txv) !== sample_out) begin n_fail++; $display("FAIL unstable_tx_byte: got %h want %h", decode(txv), sample_out); end
        n_cmp++; if (donev !== DONE_EXP) begin n_fail++; $display("FAIL unstable_done: got %h want %h", donev, DONE_EXP); end
    endtask

    task automatic test_auto();
        int cap; logic [39:0] txv, donev; bit to; logic [7:0] prev;
        cnt_in = 8'hFF; ena = 1'b1; prev = 8'h00;
        repeat (6) @(negedge clk);
        run_bg = 1'b1;
        fork
            begin
                int c;
                c = 0;
                while (run_bg) begin
                    @(negedge clk);
                    c++;
                    if (c == 200) begin c = 0; cnt_in = cnt_in + 8'd1; end
                end
            end
            begin
                auto_mode = 1'b1;
                for (int f = 0; f < 8; f++) begin
                    if (f > 0) begin
                        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL auto_back_to_back f%0d: got busy %b want 1", f, busy); end
                    end
                    if (f == 7) auto_mode = 1'b0;
                    capture_frame(-1, -1, cap, txv, donev, to);
                    n_cmp++; if (to || cap < 3 || cap > 15) begin n_fail++; $display("FAIL auto_capture f%0d: got %0d want 3..15", f, cap); end
                    if (f == 0) begin
                        n_cmp++; if (sample_out !== 8'hFF) begin n_fail++; $display("FAIL auto_first_sample: got %h want ff", sample_out); end
                    end else begin
                        n_cmp++; if (sample_out !== prev && sample_out !== prev + 8'd1) begin n_fail++; $display("FAIL auto_monotonic f%0d: got %h want %h or next", f, sample_out, prev); end
                    end
                    n_cmp++; if (decode(txv) !== sample_out) begin n_fail++; $display("FAIL auto_tx_byte f%0d: got %h want %h", f, decode(txv), sample_out); end
                    n_cmp++; if (donev !== DONE_EXP) begin n_fail++; $display("FAIL auto_done f%0d: got %h want %h", f, donev, DONE_EXP); end
                    prev = sample_out;
                end
                run_bg = 1'b0;
            end
        join
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL auto_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_ena_start();
        int cap; logic [39:0] txv, donev; bit to;
        cnt_in = 8'h3C; ena = 1'b1; auto_mode = 1'b0;
        repeat (6) @(negedge clk);
        pulse_start();
        capture_frame(20, -1, cap, txv, donev, to);
        n_cmp++; if (txv !== exp_frame(8'h3C)) begin n_fail++; $display("FAIL start_in_data_tx: got %h want %h", txv, exp_frame(8'h3C)); end
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_data_no_frame: got busy %b want 0", busy); end

        cnt_in = 8'hC3;
        repeat (6) @(negedge clk);
        auto_mode = 1'b1;
        capture_frame(-1, 18, cap, txv, donev, to);
        n_cmp++; if (to || txv !== exp_frame(8'hC3)) begin n_fail++; $display("FAIL ena_drop_tx: got %h want %h", txv, exp_frame(8'hC3)); end
        n_cmp++; if (donev !== DONE_EXP) begin n_fail++; $display("FAIL ena_drop_done: got %h want %h", donev, DONE_EXP); end
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL ena_drop_after: got busy %b tx %b want busy 0 tx 1", busy, tx); end
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ena_drop_stay_idle: got busy %b want 0", busy); end
        auto_mode = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ena_low_start: got busy %b want 0", busy); end
        ena = 1'b1;
    endtask

    task automatic test_async_reset();
        int n;
        cnt_in = 8'h00; ena = 1'b1; auto_mode = 1'b0;
        repeat (6) @(negedge clk);
        pulse_start();
        n = 0;
        while (tx === 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (17) @(negedge clk);
        n_cmp++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got tx %b busy %b want tx 0 busy 1", tx, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL arst_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL arst_idle: got busy %b tx %b want busy 0 tx 1", busy, tx); end
        n_cmp++; if (sample_out !== 8'h00) begin n_fail++; $display("FAIL arst_sample: got %h want 00", sample_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unstable();
        test_auto();
        test_ena_start();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
